// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: state_t (IDLE/CALC/DONE), DEFAULT_WIDTH, calc_cnt_w() helper.
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width: enough bits to count WIDTH iterations.
    function automatic int calc_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/prefix_sub.sv
// Combinational W-bit subtractor a - b built as a + ~b + 1 on a Kogge-Stone prefix tree.
// Latency: combinational, log2(W+1) prefix levels.
// Backpressure: none.
// Ports: a, b (W-bit operands); diff = a - b (low W bits); borrow = 1 when a < b.
module prefix_sub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // The prefix vectors carry one extra LSB that models the forced carry-in:
    // generate=1, propagate=0. After the tree, bit k holds the carry into
    // operand bit k, and the MSB holds the final carry-out.
    logic [W:0] g_v;
    logic [W:0] p_v;
    logic [W-1:0] p_bit;

    assign p_bit = a ^ ~b;

    always_comb begin
        g_v = {a & ~b, 1'b1};
        p_v = {p_bit, 1'b0};
        for (int d = 1; d < W + 1; d = d * 2) begin
            // Group terms that would reach below bit 0 shift in zeros; those
            // spans already include the carry-in position so their result is final.
            g_v = g_v | (p_v & (g_v << d));
            p_v = p_v & (p_v << d);
        end
    end

    assign diff   = p_bit ^ g_v[W-1:0];
    assign borrow = ~g_v[W];

endmodule

// File: rtl/seq_div_32bit.sv
// Iterative unsigned restoring divider, one trial subtraction per cycle, one op in flight.
// Latency: result valid WIDTH cycles after the accept edge; zero divisor resolves on the accept edge itself.
// Backpressure: result held in DONE until out_ready; in_ready stays low from accept until the cycle after consumption.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with dividend, divisor;
//        out_valid/out_ready with quotient, remainder, div_by_zero.
module seq_div_32bit
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = calc_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic             dbz_q;

    logic             accept;
    logic             step;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;

    // Restoring step: bring the next dividend bit (quotient MSB) into the
    // partial remainder and try to subtract the divisor.
    assign shifted = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};

    prefix_sub #(
        .W(WIDTH + 1)
    ) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvs_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    accept  = 1'b1;
                    state_d = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            q_q   <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            dvs_q <= divisor;
            if (divisor == '0) begin
                // Divide by zero short-circuits to the conventional result.
                q_q   <= '1;
                rem_q <= {1'b0, dividend};
                dbz_q <= 1'b1;
            end else begin
                q_q   <= dividend;
                rem_q <= '0;
                dbz_q <= 1'b0;
            end
        end else if (step) begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= borrow ? shifted : trial;
            q_q   <= {q_q[WIDTH-2:0], ~borrow};
        end
    end

    assign quotient    = q_q;
    assign remainder   = rem_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;

    // The remainder MSB only exists to hold the trial-subtraction headroom;
    // it is always 0 once an operation completes.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

endmodule
